player_renderer: RTL
====================

# player_renderer

Display-side consumer of the paddle vertical positions produced by the team controllers. Generates 640x480@60 VGA timing from the pixel clock and samples both team positions once per frame, at the frame boundary, so a paddle never tears mid-frame. Sanitises out-of-range or wrapped positions and outputs registered sync and 12-bit RGB for the pitch and the two paddles. Sits between the team controllers and the board VGA pins.

## Interface
- H_VISIBLE, 640, visible columns
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_VISIBLE, 480, visible rows
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines
- PADDLE_H, 60, paddle height in rows (even)
- PADDLE_W, 10, paddle width in columns
- TEAM1_X / TEAM2_X, 40 / 590, leftmost column of each paddle
- clk  in  1  pixel clock (25 MHz nominal); one clock domain
- rst  in  1  asynchronous, active-high reset
- team1_ver_pos  in  10  team 1 paddle centre row, unsigned
- team2_ver_pos  in  10  team 2 paddle centre row, unsigned
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while the current pixel is visible
- pixel_x  out  10  column of the current output pixel
- pixel_y  out  10  row of the current output pixel
- rgb  out  12  colour {R[3:0],G[3:0],B[3:0]}; 0 outside the visible area
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)

## Operation
- h_cnt counts 0..799 and wraps to 0; v_cnt increments when h_cnt wraps, counts 0..524, wraps to 0.
- Position latch: when h_cnt==799 and v_cnt==524, both input positions are sanitised and captured into pos1_q/pos2_q; they stay constant for the entire following frame. Input changes at any other cycle have no visible effect until the next frame.
- Sanitise (per team, on the 10-bit input p): p >= 512 → 30 (underflow wrap from the controller); 451 <= p <= 511 → 450; p < 30 → 30; else p.
- Paddle rows: pos_q - 30 .. pos_q + 29 inclusive (PADDLE_H rows). Columns: TEAMn_X .. TEAMn_X + PADDLE_W - 1.
- Colour select for a visible pixel: team 1 paddle → 12'hF00; else team 2 paddle → 12'h00F; else pitch 12'h0A0. Team 1 has priority (ranges are disjoint at defaults).
- hsync low for h_cnt 656..751; vsync low for v_cnt 490..491; visible when h_cnt < 640 and v_cnt < 480.
- Reset: h_cnt=0, v_cnt=0, pos1_q=pos2_q=240; outputs hsync=1, vsync=1, video_on=0, rgb=0, pixel_x=0, pixel_y=0, frame_start=0. Reset mid-frame aborts the frame; the first post-reset frame is drawn with positions 240.

## Timing
- All outputs are registered from the same counter state: counters at (x,y) in cycle n → pixel_x=x, pixel_y=y, hsync, vsync, video_on, rgb for (x,y) all valid in cycle n+1. One-cycle latency, all outputs mutually aligned.
- First cycle after rst deasserts: counters at (0,0); outputs show (0,0) one cycle later with frame_start=1.
- Frame period 420000 clocks; line period 800 clocks.
- frame_start high exactly once per frame.
- Latch-cycle input value is the one used; a change on the latch cycle itself is taken.

## Structure
- Shared package quidditch_pkg: VGA timing constants, colour constants (COL_PITCH, COL_TEAM1, COL_TEAM2), position width (10), reset/centre position 240.
- Sub-module vga_timing: h/v counters, hsync, vsync, video_on, frame-end strobe. player_renderer holds the position latch, sanitise logic and colour mux.

## Test plan
- Reset then run one frame with both positions 240 → 420000-cycle period; hsync low 96 clocks per line at pixel_x 656; vsync low lines 490–491; rgb=F00 at (40,210) and (49,269), 0A0 at (40,209), (40,270), (50,240); 00F at (590,240).
- team1_ver_pos=0 → after next frame boundary, team 1 rows 0..59; rgb at (45,0)=F00, (45,60)=0A0.
- team1_ver_pos=1022 (wrapped) and team2_ver_pos=470 → team 1 clamped to rows 0..59; team 2 rows 420..479, (595,479)=00F.
- Change team2_ver_pos from 240 to 100 at pixel (0,300) → remainder of that frame still centred on 240; next frame centred on 100.
- Assert rst at (320,200) for 3 cycles → outputs take reset values asynchronously; first frame_start one cycle after release+1; paddles at 240.
- Blanking check: rgb=0 for every cycle where video_on=0 across a full frame.

Source files
------------

// File: rtl/quidditch_pkg.sv
// Shared constants for the quidditch display path: VGA 640x480@60 timing,
// paddle geometry, colours and the paddle-position sanitiser.
package quidditch_pkg;

  localparam int POS_W     = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int PADDLE_H  = 60;
  localparam int PADDLE_W  = 10;
  localparam int TEAM1_X   = 40;
  localparam int TEAM2_X   = 590;

  localparam logic [POS_W-1:0] POS_CENTRE = 10'd240;

  localparam logic [11:0] COL_BLANK = 12'h000;
  localparam logic [11:0] COL_PITCH = 12'h0A0;
  localparam logic [11:0] COL_TEAM1 = 12'hF00;
  localparam logic [11:0] COL_TEAM2 = 12'h00F;

  // MSB set means the controller wrapped below zero, so it pins to the top limit.
  function automatic logic [POS_W-1:0] sanitise_pos(input logic [POS_W-1:0] p,
                                                    input logic [POS_W-1:0] lo,
                                                    input logic [POS_W-1:0] hi);
    logic [POS_W-1:0] r;
    if (p[POS_W-1]) r = lo;
    else if (p > hi) r = hi;
    else if (p < lo) r = lo;
    else r = p;
    return r;
  endfunction

endpackage

// File: rtl/player_renderer_vga_timing.sv
// Free-running VGA horizontal/vertical counters with combinational sync,
// visible-area and end-of-frame decodes taken from the counter registers.
module vga_timing
  import quidditch_pkg::*;
#(
  parameter int H_VISIBLE = quidditch_pkg::H_VISIBLE,
  parameter int H_FRONT   = quidditch_pkg::H_FRONT,
  parameter int H_SYNC    = quidditch_pkg::H_SYNC,
  parameter int H_BACK    = quidditch_pkg::H_BACK,
  parameter int V_VISIBLE = quidditch_pkg::V_VISIBLE,
  parameter int V_FRONT   = quidditch_pkg::V_FRONT,
  parameter int V_SYNC    = quidditch_pkg::V_SYNC,
  parameter int V_BACK    = quidditch_pkg::V_BACK
) (
  input  logic             clk,
  input  logic             rst,
  output logic [POS_W-1:0] h_cnt,
  output logic [POS_W-1:0] v_cnt,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             frame_end
);

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [POS_W-1:0] HS_FIRST = POS_W'(H_VISIBLE + H_FRONT);
  localparam logic [POS_W-1:0] HS_LAST  = POS_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [POS_W-1:0] VS_FIRST = POS_W'(V_VISIBLE + V_FRONT);
  localparam logic [POS_W-1:0] VS_LAST  = POS_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [POS_W-1:0] H_VIS    = POS_W'(H_VISIBLE);
  localparam logic [POS_W-1:0] V_VIS    = POS_W'(V_VISIBLE);

  logic [POS_W-1:0] h_cnt_r;
  logic [POS_W-1:0] v_cnt_r;

  // Raster counters: v advances only when h wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= 10'd0;
      if (v_cnt_r == V_LAST) v_cnt_r <= 10'd0;
      else v_cnt_r <= v_cnt_r + 10'd1;
    end else begin
      h_cnt_r <= h_cnt_r + 10'd1;
    end
  end

  always_comb begin
    h_cnt     = h_cnt_r;
    v_cnt     = v_cnt_r;
    hsync     = !((h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_LAST));
    vsync     = !((v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_LAST));
    video_on  = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
    frame_end = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
  end

endmodule

// File: rtl/player_renderer.sv
// Draws pitch and both team paddles on VGA; paddle positions are sanitised and
// latched once per frame so a paddle never tears mid-frame.
module player_renderer
  import quidditch_pkg::*;
#(
  parameter int H_VISIBLE = quidditch_pkg::H_VISIBLE,
  parameter int H_FRONT   = quidditch_pkg::H_FRONT,
  parameter int H_SYNC    = quidditch_pkg::H_SYNC,
  parameter int H_BACK    = quidditch_pkg::H_BACK,
  parameter int V_VISIBLE = quidditch_pkg::V_VISIBLE,
  parameter int V_FRONT   = quidditch_pkg::V_FRONT,
  parameter int V_SYNC    = quidditch_pkg::V_SYNC,
  parameter int V_BACK    = quidditch_pkg::V_BACK,
  parameter int PADDLE_H  = quidditch_pkg::PADDLE_H,
  parameter int PADDLE_W  = quidditch_pkg::PADDLE_W,
  parameter int TEAM1_X   = quidditch_pkg::TEAM1_X,
  parameter int TEAM2_X   = quidditch_pkg::TEAM2_X,
  parameter logic [POS_W-1:0] RESET_POS = POS_CENTRE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] team1_ver_pos,
  input  logic [POS_W-1:0] team2_ver_pos,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [POS_W-1:0] pixel_x,
  output logic [POS_W-1:0] pixel_y,
  output logic [11:0]      rgb,
  output logic             frame_start
);

  localparam logic [POS_W-1:0] POS_LO   = POS_W'(PADDLE_H / 2);
  localparam logic [POS_W-1:0] POS_HI   = POS_W'(V_VISIBLE - PADDLE_H / 2);
  localparam logic [POS_W:0]   HALF     = 11'(PADDLE_H / 2);
  localparam logic [POS_W:0]   HALF_M1  = 11'(PADDLE_H / 2 - 1);
  localparam logic [POS_W-1:0] T1_LEFT  = POS_W'(TEAM1_X);
  localparam logic [POS_W-1:0] T1_RIGHT = POS_W'(TEAM1_X + PADDLE_W - 1);
  localparam logic [POS_W-1:0] T2_LEFT  = POS_W'(TEAM2_X);
  localparam logic [POS_W-1:0] T2_RIGHT = POS_W'(TEAM2_X + PADDLE_W - 1);

  logic [POS_W-1:0] h_cnt_s, v_cnt_s;
  logic             hsync_s, vsync_s, video_on_s, frame_end_s;
  logic [POS_W-1:0] pos1_r, pos2_r;
  logic [POS_W:0]   row_s;
  logic             on_team1_s, on_team2_s;
  logic [11:0]      rgb_s;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt_s),
    .v_cnt     (v_cnt_s),
    .hsync     (hsync_s),
    .vsync     (vsync_s),
    .video_on  (video_on_s),
    .frame_end (frame_end_s)
  );

  // Positions change only on the last pixel of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos1_r <= RESET_POS;
      pos2_r <= RESET_POS;
    end else if (frame_end_s) begin
      pos1_r <= sanitise_pos(team1_ver_pos, POS_LO, POS_HI);
      pos2_r <= sanitise_pos(team2_ver_pos, POS_LO, POS_HI);
    end
  end

  // Row test as row + HALF >= pos avoids underflow of pos - HALF.
  always_comb begin
    row_s      = {1'b0, v_cnt_s};
    on_team1_s = (h_cnt_s >= T1_LEFT) && (h_cnt_s <= T1_RIGHT) &&
                 (row_s + HALF >= {1'b0, pos1_r}) && (row_s <= {1'b0, pos1_r} + HALF_M1);
    on_team2_s = (h_cnt_s >= T2_LEFT) && (h_cnt_s <= T2_RIGHT) &&
                 (row_s + HALF >= {1'b0, pos2_r}) && (row_s <= {1'b0, pos2_r} + HALF_M1);
    if (!video_on_s) rgb_s = COL_BLANK;
    else if (on_team1_s) rgb_s = COL_TEAM1;
    else if (on_team2_s) rgb_s = COL_TEAM2;
    else rgb_s = COL_PITCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pixel_x     <= 10'd0;
      pixel_y     <= 10'd0;
      rgb         <= 12'h000;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_s;
      vsync       <= vsync_s;
      video_on    <= video_on_s;
      pixel_x     <= h_cnt_s;
      pixel_y     <= v_cnt_s;
      rgb         <= rgb_s;
      frame_start <= (h_cnt_s == 10'd0) && (v_cnt_s == 10'd0);
    end
  end

endmodule
